// File: rtl/jellyvl_etherneco_pkg.sv
// jellyvl_etherneco_pkg: states, line constants and bit helpers shared by the etherneco tx and rx.
package jellyvl_etherneco_pkg;
  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    PREAMBLE = 7'b0000010,
    SFD      = 7'b0000100,
    LENGTH   = 7'b0001000,
    PAYLOAD  = 7'b0010000,
    FCS      = 7'b0100000,
    GAP      = 7'b1000000
  } state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hd5;
  localparam logic [31:0] CRC_RESIDUE = 32'h2144df1c;
  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction
  // The MSB-first engine holds the reflected CRC bit-reversed; undo that and apply the final inversion.
  function automatic logic [31:0] fcs_of(input logic [31:0] r);
    for (int i = 0; i < 32; i++) fcs_of[i] = ~r[31-i];
  endfunction
endpackage

// File: rtl/jelly2_calc_crc.sv
// jelly2_calc_crc: registered MSB-first CRC engine; in_update=0 restarts from all-ones before the byte.
module jelly2_calc_crc #(
  parameter int DATA_WIDTH = 8,
  parameter int CRC_WIDTH = 32,
  parameter logic [CRC_WIDTH-1:0] POLY_REPS = 32'h04c11db7,
  parameter bit REVERSED = 1'b0
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  in_update,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [CRC_WIDTH-1:0]  out_crc
);
  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  always_comb begin
    crc_d = in_update ? crc_q : '1;
    for (int i = 0; i < DATA_WIDTH; i++)
      crc_d = {crc_d[CRC_WIDTH-2:0], 1'b0} ^ ((crc_d[CRC_WIDTH-1] ^ in_data[REVERSED ? i : DATA_WIDTH-1-i]) ? POLY_REPS : '0);
    crc_d = in_valid ? crc_d : crc_q;
  end
  always_ff @(posedge clk) crc_q <= reset ? '1 : crc_d;
  assign out_crc = crc_q;
endmodule

// File: rtl/jellyvl_etherneco_tx.sv
// jellyvl_etherneco_tx: frames a payload as preamble/SFD/length/payload/FCS then holds an idle gap.
// JELLYVL_ETHERNECO_TX_LENGTH_CHECK_EN enables s_last versus tx_length checking with tx_error.
module jellyvl_etherneco_tx
  import jellyvl_etherneco_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int GAP_LEN = 12
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        tx_start,
  input  logic [15:0] tx_length,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_error,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        m_first,
  output logic        m_last,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready
);
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d;
  logic [31:0] fcs_q, fcs_d, fcs_w, fcs_sel, crc;
  logic [7:0] m_data_q, m_data_d, ld_byte, crc_in;
  logic m_valid_q, m_valid_d, m_first_q, m_first_d, m_last_q, m_last_d;
  logic tx_done_q, tx_done_d, tx_error_q, tx_error_d, drain_q, drain_d;
  logic ld, is_first, is_last, crc_en, crc_upd, free, take, early, short_len;
  assign free = !m_valid_q || m_ready;
  assign s_ready = state_q == PAYLOAD && free;
  assign take = s_valid && s_ready;
  assign fcs_w = fcs_of(crc);
  assign crc_in = rev8(ld_byte);
`ifdef JELLYVL_ETHERNECO_TX_LENGTH_CHECK_EN
  assign early = s_last && cnt_q != 16'd0;
  assign short_len = !s_last && cnt_q == 16'd0;
`else
  assign early = 1'b0;
  assign short_len = 1'b0;
`endif
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = tx_start ? PREAMBLE : IDLE;
      PREAMBLE: state_d = free && cnt_q == 16'(PREAMBLE_LEN - 1) ? SFD : PREAMBLE;
      SFD:      state_d = free ? LENGTH : SFD;
      LENGTH:   state_d = free && cnt_q[0] ? PAYLOAD : LENGTH;
      PAYLOAD:  state_d = !take ? PAYLOAD : drain_q ? (s_last ? GAP : PAYLOAD) : ((cnt_q == 16'd0 && !short_len) || early) ? FCS : PAYLOAD;
      FCS:      state_d = free && cnt_q[2] ? GAP : FCS;
      GAP:      state_d = cnt_q == 16'(GAP_LEN - 1) ? IDLE : GAP;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    ld = 1'b0;
    ld_byte = PREAMBLE_BYTE;
    is_first = 1'b0;
    is_last = 1'b0;
    crc_en = 1'b0;
    crc_upd = 1'b1;
    len_d = len_q;
    cnt_d = cnt_q;
    fcs_d = fcs_q;
    fcs_sel = cnt_q[1:0] == 2'd0 ? fcs_w : fcs_q;
    drain_d = drain_q;
    tx_done_d = 1'b0;
    tx_error_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        len_d = tx_start ? tx_length : len_q;
        cnt_d = 16'd0;
      end
      PREAMBLE: begin
        ld = free;
        is_first = cnt_q == 16'd0;
        cnt_d = !free ? cnt_q : cnt_q == 16'(PREAMBLE_LEN - 1) ? 16'd0 : cnt_q + 16'd1;
      end
      SFD: begin
        ld = free;
        ld_byte = SFD_BYTE;
      end
      LENGTH: begin
        ld = free;
        ld_byte = cnt_q[0] ? len_q[15:8] : len_q[7:0];
        crc_en = ld;
        crc_upd = cnt_q[0];
        cnt_d = !free ? cnt_q : cnt_q[0] ? len_q : 16'd1;
      end
      PAYLOAD: begin
        ld = take && !drain_q;
        ld_byte = s_data;
        crc_en = ld;
        tx_error_d = ld && (early || short_len);
        drain_d = drain_q || (ld && short_len);
        cnt_d = drain_q ? 16'd0 : !ld ? cnt_q : ((cnt_q == 16'd0 && !short_len) || early) ? 16'd0 : cnt_q - 16'd1;
      end
      FCS: begin
        ld = free && !cnt_q[2];
        ld_byte = fcs_sel[{cnt_q[1:0], 3'b000} +: 8];
        is_last = cnt_q[1:0] == 2'd3;
        crc_en = ld;
        fcs_d = ld && cnt_q[1:0] == 2'd0 ? fcs_w : fcs_q;
        tx_done_d = free && cnt_q[2];
        cnt_d = tx_done_d ? 16'd0 : ld ? cnt_q + 16'd1 : cnt_q;
      end
      GAP: begin
        drain_d = 1'b0;
        cnt_d = cnt_q + 16'd1;
      end
      default: ;
    endcase
    m_valid_d = ld || (m_valid_q && !free);
    m_data_d = ld ? ld_byte : m_data_q;
    m_first_d = ld ? is_first : m_first_q;
    m_last_d = ld ? is_last : m_last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= 16'd0;
      cnt_q <= 16'd0;
      fcs_q <= 32'd0;
      m_data_q <= 8'd0;
      m_valid_q <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q <= 1'b0;
      tx_done_q <= 1'b0;
      tx_error_q <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
      fcs_q <= fcs_d;
      m_data_q <= m_data_d;
      m_valid_q <= m_valid_d;
      m_first_q <= m_first_d;
      m_last_q <= m_last_d;
      tx_done_q <= tx_done_d;
      tx_error_q <= tx_error_d;
      drain_q <= drain_d;
    end
  end
  jelly2_calc_crc #(
    .DATA_WIDTH(8),
    .CRC_WIDTH(32),
    .POLY_REPS(32'h04c11db7),
    .REVERSED(1'b0)
  ) u_crc (
    .reset(reset),
    .clk(clk),
    .in_update(crc_upd),
    .in_data(crc_in),
    .in_valid(crc_en),
    .out_crc(crc)
  );
  assign tx_busy = state_q != IDLE;
  assign tx_done = tx_done_q;
  assign tx_error = tx_error_q;
  assign m_data = m_data_q;
  assign m_valid = m_valid_q;
  assign m_first = m_first_q;
  assign m_last = m_last_q;
endmodule

// File: tb/tb_jellyvl_etherneco_tx.sv
// tb_jellyvl_etherneco_tx: random frames against a byte-list model with a zlib-style CRC-32.
module tb_jellyvl_etherneco_tx;
  import jellyvl_etherneco_pkg::*;
  typedef logic [7:0] u8;
  localparam int PRE = 7;
  localparam int GAPN = 12;
  logic reset, clk = 1'b0, tx_start, tx_busy, tx_done, tx_error;
  logic [15:0] tx_length;
  logic [7:0] s_data, m_data;
  logic s_last, s_valid, s_ready, m_first, m_last, m_valid, m_ready;
  int checks = 0, errors = 0;
  u8 src[$];
  u8 pay[$];

  jellyvl_etherneco_tx #(.PREAMBLE_LEN(PRE), .GAP_LEN(GAPN)) dut (
    .reset(reset), .clk(clk), .tx_start(tx_start), .tx_length(tx_length),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_first(m_first), .m_last(m_last), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input u8 q[$]);
    logic [31:0] c = 32'hffffffff;
    foreach (q[i]) begin
      c ^= {24'd0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hedb88320 : c >> 1;
    end
    return ~c;
  endfunction

  // mode: 0 sink always ready, 1 sink toggles, 2 sink random; abort_at>0 leaves mid-frame.
  task automatic run_frame(input int len_m1, input int last_at, input int mode, input bit stall, input int abort_at);
    u8 exp[$], got[$], body[$], tail[$];
    bit gf[$], gl[$];
    logic [15:0] l16;
    logic [31:0] c;
    logic [7:0] pd;
    bit has_fcs, pv, pr, pf, pl, tog;
    int n_src, n_out, exp_err, exp_cons, budget, cyc, pidx, t_last, t_done, t_idle, errs, dones, gap_valid, bad_first, bad_last;
    n_src = (len_m1 > last_at ? len_m1 : last_at) + 1;
    if (src.size() == 0) repeat (n_src) src.push_back(u8'($urandom));
    n_out = len_m1 + 1; has_fcs = 1; exp_err = 0; exp_cons = len_m1 + 1;
`ifdef JELLYVL_ETHERNECO_TX_LENGTH_CHECK_EN
    if (last_at < len_m1) begin n_out = last_at + 1; exp_err = 1; exp_cons = n_out; end
    else if (last_at > len_m1) begin has_fcs = 0; exp_err = 1; exp_cons = last_at + 1; end
`endif
    l16 = 16'(len_m1);
    body.push_back(l16[7:0]);
    body.push_back(l16[15:8]);
    for (int i = 0; i < n_out; i++) body.push_back(src[i]);
    repeat (PRE) exp.push_back(8'h55);
    exp.push_back(8'hd5);
    foreach (body[i]) exp.push_back(body[i]);
    c = crc32(body);
    if (has_fcs) for (int i = 0; i < 4; i++) exp.push_back(c[8*i +: 8]);
    budget = 400 + 8 * (n_src + 16);
    cyc = 0; pidx = 0; t_last = -1; t_done = -1; t_idle = -1; errs = 0; dones = 0; gap_valid = 0;
    pv = 0; pr = 0; pd = 0; pf = 0; pl = 0; tog = 0;
    while (cyc < budget) begin
      if (cyc > 0) @(negedge clk);
      tx_start = cyc == 0 || cyc == 5;
      tx_length = cyc == 0 ? l16 : 16'($urandom);
      m_ready = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom);
      tog = !tog;
      s_valid = pidx < n_src && (!stall || $urandom_range(0, 2) != 0);
      s_data = pidx < n_src ? src[pidx] : u8'($urandom);
      s_last = pidx == last_at;
      #1;
      if (abort_at > 0 && cyc == abort_at) begin
        src.delete();
        return;
      end
      if (pv && !pr) chk($sformatf("hold@%0d", cyc), {m_valid, m_first, m_last, m_data}, {1'b1, pf, pl, pd});
      if (cyc == 1) chk("busy_start", {31'd0, tx_busy}, 1);
      if (t_done >= 0 && m_valid) gap_valid++;
      if (tx_error) errs++;
      if (tx_done) begin dones++; if (t_done < 0) t_done = cyc; end
      if (cyc > 0 && !tx_busy) begin t_idle = cyc; break; end
      if (s_valid && s_ready) pidx++;
      if (m_valid && m_ready) begin
        got.push_back(m_data); gf.push_back(m_first); gl.push_back(m_last); t_last = cyc;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pf = m_first; pl = m_last;
      @(posedge clk);
      cyc++;
    end
    tx_start = 0; s_valid = 0; s_last = 0; m_ready = 1;
    chk("complete", {31'd0, t_idle >= 0}, 1);
    chk("nbytes", got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk($sformatf("byte%0d", i), {24'd0, got[i]}, {24'd0, exp[i]});
    bad_first = 0; bad_last = 0;
    foreach (gf[i]) if (gf[i] != (i == 0)) bad_first++;
    foreach (gl[i]) if (gl[i] != (has_fcs && i == exp.size() - 1)) bad_last++;
    chk("first_flag", bad_first, 0);
    chk("last_flag", bad_last, 0);
    if (has_fcs) begin
      tail = got[PRE+1:$];
      chk("residue", crc32(tail), CRC_RESIDUE);
      chk("done_once", dones, 1);
      chk("done_lat", t_done, t_last + 1);
      chk("gap_len", t_idle, t_done + GAPN);
      chk("gap_valid", gap_valid, 0);
    end else chk("no_done", dones, 0);
    chk("error", errs, exp_err);
    chk("consumed", pidx, exp_cons);
    src.delete();
  endtask

  initial begin
    reset = 1; tx_start = 0; tx_length = 0; s_valid = 0; s_data = 0; s_last = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", {31'd0, tx_busy}, 0);
    chk("rst_mvalid", {31'd0, m_valid}, 0);
    chk("rst_sready", {31'd0, s_ready}, 0);
    chk("rst_done", {31'd0, tx_done}, 0);
    chk("rst_error", {31'd0, tx_error}, 0);
    reset = 0;
    src = {8'ha5};
    run_frame(0, 0, 0, 0, 0);
    repeat (16) pay.push_back(u8'($urandom));
    src = pay; run_frame(15, 15, 0, 0, 0);
    src = pay; run_frame(15, 15, 1, 0, 0);
    repeat (6) begin
      automatic int l = $urandom_range(0, 40);
      run_frame(l, l, 2, 1, 0);
    end
    run_frame(299, 299, 2, 1, 0);
`ifdef JELLYVL_ETHERNECO_TX_LENGTH_CHECK_EN
    run_frame(7, 3, 0, 0, 0);
    run_frame(1, 3, 2, 1, 0);
`else
    run_frame(9, 2, 2, 0, 0);
`endif
    run_frame(30, 30, 0, 0, 25);
    reset = 1;
    @(posedge clk); @(negedge clk); #1;
    chk("abort_mvalid", {31'd0, m_valid}, 0);
    chk("abort_busy", {31'd0, tx_busy}, 0);
    chk("abort_sready", {31'd0, s_ready}, 0);
    chk("abort_done", {31'd0, tx_done}, 0);
    @(posedge clk); @(negedge clk); #1;
    chk("abort_mvalid2", {31'd0, m_valid}, 0);
    reset = 0;
    run_frame(5, 5, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jellyvl_etherneco_tx.md
JELLYVL_ETHERNECO_TX -- requirements
Module: jellyvl_etherneco_tx

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 7, number of 0x55 bytes before the SFD (legal range 6..8).
REQ-002 SHALL have parameter GAP_LEN, default 12, number of idle cycles enforced after a frame's last byte.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have the following ports, one per line:
- reset  in  1  synchronous, active-high
- clk  in  1  clock
- tx_start  in  1  frame request pulse
- tx_length  in  16  payload byte count minus one, sampled with tx_start
- tx_busy  out  1  high from the accepted tx_start until the end of the gap
- tx_done  out  1  one-cycle pulse after the last FCS byte is accepted
- tx_error  out  1  one-cycle pulse on a payload length mismatch (see Configuration)
- s_data  in  8  payload byte
- s_last  in  1  marks the last payload byte
- s_valid  in  1  payload byte valid
- s_ready  out  1  payload byte accepted
- m_first  out  1  first byte of a frame (first preamble byte)
- m_last  out  1  last byte of a frame (final FCS byte)
- m_data  out  8  line byte
- m_valid  out  1  line byte valid
- m_ready  in  1  line sink accepts the byte

Function
REQ-005 SHALL implement states IDLE, PREAMBLE, SFD, LENGTH, PAYLOAD, FCS, GAP, one-hot encoded.
REQ-006 SHALL accept tx_start only in IDLE, latch tx_length, and enter PREAMBLE on the next cycle; tx_start outside IDLE SHALL be ignored.
REQ-007 SHALL emit the frame as: PREAMBLE_LEN bytes of 0x55 (first carries m_first=1), one 0xD5, length low byte, length high byte, tx_length+1 payload bytes, 4 FCS bytes (last carries m_last=1).
REQ-008 SHALL hold m_data, m_first and m_last stable while m_valid=1 and m_ready=0; a byte transfers only when m_valid and m_ready are both high.
REQ-009 SHALL pass payload with s_ready = (state==PAYLOAD) && (!m_valid || m_ready), and m_data SHALL be registered, giving a latency of 1 cycle from s_data to m_data.
REQ-010 SHALL drop m_valid during PAYLOAD while s_valid=0 (frame stall) and SHALL NOT insert filler bytes.
REQ-011 SHALL run the CRC over the length bytes, payload and FCS: reset on the first length byte, update on every transferred byte.
REQ-012 SHALL choose the four FCS bytes so that the running CRC over length+payload+FCS equals 32'h2144df1c, matching the receiver's check.
REQ-013 SHALL use 16-bit wrap-free counting: the payload down-counter starts at tx_length, and PAYLOAD ends on the transfer at count 0; tx_length=0 sends exactly 1 byte and 0xFFFF sends 65536 bytes.
REQ-014 SHALL, after the last FCS byte transfers, pulse tx_done, then hold GAP for GAP_LEN cycles with m_valid=0, then return to IDLE with tx_busy=0.
REQ-015 SHALL keep all outputs other than the m_* bus deasserted outside their pulses; m_data/m_first/m_last SHALL be don't-care while m_valid=0.

Reset
REQ-016 SHALL, on reset (including mid-frame), go to IDLE and force tx_busy=0, tx_done=0, tx_error=0, s_ready=0, m_valid=0; the aborted frame is not resumed.
REQ-017 SHALL accept tx_start on the first cycle after reset deasserts.

Configuration
REQ-018 SHALL, with JELLYVL_ETHERNECO_TX_LENGTH_CHECK_EN defined, compare s_last against the counter in two cases:
- s_last before count 0: pulse tx_error, emit the FCS anyway.
- count 0 without s_last: pulse tx_error, then drain and discard input bytes until s_last, holding s_ready=1 and m_valid=0, before the gap.
REQ-019 SHALL, without JELLYVL_ETHERNECO_TX_LENGTH_CHECK_EN, ignore s_last and tie tx_error to 0.

Structure
REQ-020 SHALL place the state enum, the preamble/SFD constants (0x55, 0xD5) and the CRC residue constant 32'h2144df1c in shared package jellyvl_etherneco_pkg, which the receiver also uses.
REQ-021 SHALL instantiate jelly2_calc_crc (DATA_WIDTH 8, CRC_WIDTH 32, POLY_REPS 32'h04C11DB7, REVERSED 0) as its only sub-module.

Verification
REQ-022 tx_start, tx_length=0, payload 0xA5, m_ready=1 -> 55×7, D5, 00, 00, A5, 4 FCS; m_last on the 15th byte; tx_done 1 cycle later.
REQ-023 tx_length=3, payload 01 02 03 04, looped back into jellyvl_etherneco_rx -> rx_start, rx_length=3, m_data 01..04, rx_end=1, rx_error=0.
REQ-024 m_ready toggled 1/0 every cycle with 16-byte payload -> output byte stream identical to the m_ready=1 case and no byte duplicated or lost.
REQ-025 With LENGTH_CHECK_EN, tx_length=7 and s_last on the 4th byte -> tx_error pulse; with tx_length=1 and 4 bytes sent -> tx_error pulse, then 2 bytes drained; both return to IDLE.
REQ-026 Reset asserted mid-payload, then tx_start on the first free cycle -> m_valid=0 during reset, and a clean new frame starting with m_first on 0x55.
